// File: rtl/bitrev_pkg.sv
// Shared types and constants for the bit-reversal scheduler.
// reverse() is the word-level golden function the shift engine must match.
package bitrev_pkg;

    localparam int MAX_DEF  = 8;
    localparam int NREQ_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // out[MAX-1-k] = din[k]
    function automatic logic [MAX_DEF-1:0] reverse(input logic [MAX_DEF-1:0] d);
        logic [MAX_DEF-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_DEF; k++) begin
            r[MAX_DEF-1-k] = d[k];
        end
        return r;
    endfunction

endpackage : bitrev_pkg

// File: rtl/bitrev_rr_arbiter.sv
// Combinational round-robin winner search starting one past the last winner.
// The last winner is owned by the caller so it only advances on a real capture.
module bitrev_rr_arbiter
    import bitrev_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_id,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    always_comb begin
        int         idx;
        logic       found;
        logic [IDW-1:0] idx_w;
        winner = '0;
        any    = |req;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        // Offsets 1..NREQ visit every requester once, last winner last.
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(last_id) + k) % NREQ;
            idx_w = IDW'(idx);
            if (!found && req[idx_w]) begin
                winner = idx_w;
                found  = 1'b1;
            end
        end
    end

endmodule : bitrev_rr_arbiter

// File: rtl/bitrev_sched.sv
// Round-robin scheduler sharing one serial bit-reversal engine between NREQ
// requesters; one result bit is produced per clock.
module bitrev_sched
    import bitrev_pkg::*;
#(
    parameter  int MAX  = MAX_DEF,
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = $clog2(MAX)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*MAX-1:0] din,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [MAX-1:0]    dout,
    output logic [IDW-1:0]    dout_id,
    output logic              dout_valid,
    output state_e            state_dbg
);

    // Handshake: a requester raises req with din stable and holds both until it
    // sees its one-cycle gnt bit; din is sampled on the edge that raises gnt.
    // Results are announced by a one-cycle dout_valid; there is no back-pressure.

    state_e               state_q, state_d;
    logic [MAX-1:0]       src_q, src_d;
    logic [MAX-2:0]       acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IDW-1:0]       last_id_q, last_id_d;
    logic [IDW-1:0]       cur_id_q, cur_id_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [MAX-1:0]       dout_q, dout_d;
    logic [IDW-1:0]       dout_id_q, dout_id_d;
    logic                 dout_valid_q, dout_valid_d;

    logic [IDW-1:0]       arb_winner;
    logic                 arb_any;
    logic [MAX-1:0]       din_arr [NREQ];
    logic [MAX-1:0]       shifted;

    bitrev_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req),
        .last_id (last_id_q),
        .winner  (arb_winner),
        .any     (arb_any)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            din_arr[i] = din[i*MAX +: MAX];
        end
    end

    // The accumulator only needs MAX-1 bits; the final shift lands straight in dout.
    assign shifted = {acc_q, src_q[0]};

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        last_id_d    = last_id_q;
        cur_id_d     = cur_id_q;
        gnt_d        = '0;
        dout_d       = dout_q;
        dout_id_d    = dout_id_q;
        dout_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d           = SHIFT;
                    src_d             = din_arr[arb_winner];
                    acc_d             = '0;
                    cnt_d             = '0;
                    last_id_d         = arb_winner;
                    cur_id_d          = arb_winner;
                    gnt_d[arb_winner] = 1'b1;
                end
            end
            SHIFT: begin
                acc_d = shifted[MAX-2:0];
                src_d = src_q >> 1;
                if (cnt_q == CW'(MAX-1)) begin
                    state_d      = IDLE;
                    dout_d       = shifted;
                    dout_id_d    = cur_id_q;
                    dout_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            src_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            last_id_q    <= IDW'(NREQ-1);
            cur_id_q     <= '0;
            gnt_q        <= '0;
            dout_q       <= '0;
            dout_id_q    <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            last_id_q    <= last_id_d;
            cur_id_q     <= cur_id_d;
            gnt_q        <= gnt_d;
            dout_q       <= dout_d;
            dout_id_q    <= dout_id_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = (state_q != IDLE);
    assign dout       = dout_q;
    assign dout_id    = dout_id_q;
    assign dout_valid = dout_valid_q;
    assign state_dbg  = state_q;

endmodule : bitrev_sched

// File: tb/tb_bitrev_sched.sv
// Self-checking bench for bitrev_sched: directed scenarios plus randomized
// request batches checked against a transaction-level round-robin model.
module tb_bitrev_sched;
    import bitrev_pkg::*;

    localparam int MAX  = 8;
    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] din = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  dout;
    logic [1:0]  dout_id;
    logic        dout_valid;
    state_e      state_dbg;

    int checks = 0;
    int fails  = 0;
    int last_id_m;
    int gnt_log[$];
    int gnt_t[$];

    always #5 clk = ~clk;

    bitrev_sched #(.MAX(MAX), .NREQ(NREQ)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .busy       (busy),
        .dout       (dout),
        .dout_id    (dout_id),
        .dout_valid (dout_valid),
        .state_dbg  (state_dbg)
    );

    // Round-robin rule: first pending requester after the previous winner.
    function automatic int rr_pick(input logic [3:0] p, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        req = '0;
        step();
        step();
        reset_n = 1'b1;
        last_id_m = NREQ - 1;
    endtask

    // Requesters in mask raise req; those not in hold drop it on their gnt.
    // Every grant, result, busy level and spacing is checked against the model.
    task automatic run_batch(input string name, input logic [3:0] mask,
                             input logic [3:0] hold, input logic [31:0] dins,
                             input int n_grants);
        logic [3:0] pend, pa;
        logic [7:0] exp_q[$];
        int         id_q[$];
        int         seen, gstep, step_n, exp_w;
        logic [7:0] exp_d;
        int         exp_id;
        logic       exp_busy;
        pend = mask;
        din = dins;
        req = pend;
        seen = 0;
        gstep = -100;
        step_n = 0;
        gnt_log.delete();
        gnt_t.delete();
        while ((seen < n_grants || exp_q.size() > 0) && step_n < 400) begin
            pa = pend;
            step();
            step_n++;
            if (dout_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s unexpected_dout_valid: got dout=%h, expected no result", name, dout);
                end else begin
                    exp_d = exp_q.pop_front();
                    exp_id = id_q.pop_front();
                    if (dout !== exp_d) begin
                        fails++;
                        $display("FAIL %s dout: got %h expected %h", name, dout, exp_d);
                    end
                    checks++;
                    if (dout_id !== 2'(exp_id)) begin
                        fails++;
                        $display("FAIL %s dout_id: got %0d expected %0d", name, dout_id, exp_id);
                    end
                    checks++;
                    if (step_n - gstep != MAX) begin
                        fails++;
                        $display("FAIL %s latency: got %0d expected %0d", name, step_n - gstep, MAX);
                    end
                    checks++;
                    if (gnt !== 4'b0000) begin
                        fails++;
                        $display("FAIL %s gnt_overlaps_valid: got %b expected 0000", name, gnt);
                    end
                end
            end
            if (gnt !== 4'b0000) begin
                exp_w = rr_pick(pa, last_id_m);
                checks++;
                if (exp_w < 0) begin
                    fails++;
                    $display("FAIL %s unexpected_gnt: got %b expected 0000", name, gnt);
                end else begin
                    if (gnt !== 4'(1 << exp_w)) begin
                        fails++;
                        $display("FAIL %s gnt: got %b expected %b", name, gnt, 4'(1 << exp_w));
                    end
                    if (seen > 0) begin
                        checks++;
                        if (step_n - gstep < MAX + 1) begin
                            fails++;
                            $display("FAIL %s gnt_spacing: got %0d expected >= %0d", name, step_n - gstep, MAX + 1);
                        end
                    end
                    exp_q.push_back(reverse(dins[exp_w*8 +: 8]));
                    id_q.push_back(exp_w);
                    gnt_log.push_back(exp_w);
                    gnt_t.push_back(step_n);
                    last_id_m = exp_w;
                    gstep = step_n;
                    seen++;
                    if (!hold[exp_w]) pend[exp_w] = 1'b0;
                    if (seen == n_grants) pend = '0;
                    req = pend;
                end
            end
            exp_busy = (seen > 0) && (step_n - gstep <= MAX - 1);
            checks++;
            if (busy !== exp_busy || state_dbg !== (exp_busy ? SHIFT : IDLE)) begin
                fails++;
                $display("FAIL %s busy: got %b/%0d expected %b", name, busy, state_dbg, exp_busy);
            end
        end
        checks++;
        if (step_n >= 400) begin
            fails++;
            $display("FAIL %s timeout: got %0d grants expected %0d", name, seen, n_grants);
        end
        req = '0;
    endtask

    task automatic wait_valid(output int n, input int bound);
        n = 0;
        do begin
            step();
            n++;
        end while (dout_valid !== 1'b1 && n < bound);
    endtask

    task automatic test_reset;
        logic [7:0] x;
        int n;
        x = 8'($urandom);
        reset_n = 1'b0;
        req = 4'hF;
        din = {24'($urandom), x};
        step();
        step();
        checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++; if (dout_id !== 2'd0) begin fails++; $display("FAIL reset_dout_id: got %0d expected 0", dout_id); end
        checks++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
        reset_n = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (gnt === 4'b0000 && n < 5);
        checks++;
        if (gnt !== 4'b0001) begin fails++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
        req = '0;
        wait_valid(n, 12);
        checks++;
        if (dout_valid !== 1'b1 || dout !== reverse(x)) begin
            fails++;
            $display("FAIL reset_first_result: got %h/%b expected %h", dout, dout_valid, reverse(x));
        end
        step();
    endtask

    task automatic test_single;
        do_reset();
        run_batch("single", 4'b0001, 4'b0000, 32'h0000_0001, 1);
        checks++;
        if (dout !== 8'h80 || dout_id !== 2'd0) begin
            fails++;
            $display("FAIL single_final: got %h/%0d expected 80/0", dout, dout_id);
        end
    endtask

    task automatic test_all_four;
        do_reset();
        run_batch("all_four", 4'b1111, 4'b0000, {8'h01, 8'h3C, 8'h0F, 8'hA0}, 4);
        checks++;
        if (gnt_log.size() != 4 || gnt_log[0] != 0 || gnt_log[1] != 1 || gnt_log[2] != 2 || gnt_log[3] != 3) begin
            fails++;
            $display("FAIL all_four_order: got %p expected '{0,1,2,3}", gnt_log);
        end
        for (int i = 1; i < gnt_t.size(); i++) begin
            checks++;
            if (gnt_t[i] - gnt_t[i-1] != MAX + 1) begin
                fails++;
                $display("FAIL all_four_gap: got %0d expected %0d", gnt_t[i] - gnt_t[i-1], MAX + 1);
            end
        end
        checks++;
        if (dout !== 8'h80 || dout_id !== 2'd3) begin
            fails++;
            $display("FAIL all_four_final: got %h/%0d expected 80/3", dout, dout_id);
        end
    endtask

    task automatic test_fairness;
        do_reset();
        run_batch("fair", 4'b1010, 4'b1010, 32'($urandom), 4);
        checks++;
        if (gnt_log.size() != 4 || gnt_log[0] != 1 || gnt_log[1] != 3 || gnt_log[2] != 1 || gnt_log[3] != 3) begin
            fails++;
            $display("FAIL fair_order: got %p expected '{1,3,1,3}", gnt_log);
        end
        for (int i = 1; i < gnt_t.size(); i++) begin
            checks++;
            if (gnt_t[i] - gnt_t[i-1] != MAX + 1) begin
                fails++;
                $display("FAIL fair_gap: got %0d expected %0d", gnt_t[i] - gnt_t[i-1], MAX + 1);
            end
        end
    endtask

    task automatic test_late_request;
        logic [7:0] x, y;
        int n;
        bit dv_seen, early;
        do_reset();
        x = 8'($urandom);
        y = 8'($urandom);
        din = '0;
        din[7:0] = x;
        req = 4'b0001;
        n = 0;
        do begin
            step();
            n++;
        end while (gnt === 4'b0000 && n < 5);
        checks++;
        if (gnt !== 4'b0001) begin fails++; $display("FAIL late_first_gnt: got %b expected 0001", gnt); end
        req = '0;
        step();
        step();
        step();
        req = 4'b0100;
        din[23:16] = y;
        dv_seen = 0;
        early = 0;
        n = 0;
        while (!dv_seen && n < 15) begin
            step();
            n++;
            if (gnt !== 4'b0000) early = 1;
            if (dout_valid === 1'b1) dv_seen = 1;
        end
        checks++;
        if (early) begin fails++; $display("FAIL late_early_gnt: got grant before result expected none"); end
        checks++;
        if (!dv_seen || n != MAX - 3 || dout !== reverse(x)) begin
            fails++;
            $display("FAIL late_first_result: got %h after %0d expected %h after %0d", dout, n, reverse(x), MAX - 3);
        end
        step();
        checks++;
        if (gnt !== 4'b0100) begin fails++; $display("FAIL late_gnt: got %b expected 0100", gnt); end
        req = '0;
        wait_valid(n, 12);
        checks++;
        if (dout_valid !== 1'b1 || n != MAX || dout !== reverse(y) || dout_id !== 2'd2) begin
            fails++;
            $display("FAIL late_result: got %h/%0d after %0d expected %h/2 after %0d", dout, dout_id, n, reverse(y), MAX);
        end
        step();
    endtask

    task automatic test_mid_reset;
        logic [7:0] x, y;
        int n;
        bit dv_bad;
        do_reset();
        x = 8'($urandom);
        y = 8'($urandom);
        din = '0;
        din[7:0] = x;
        req = 4'b0001;
        n = 0;
        do begin
            step();
            n++;
        end while (gnt === 4'b0000 && n < 5);
        req = '0;
        repeat (4) step();
        reset_n = 1'b0;
        req = 4'b1000;
        din[31:24] = y;
        step();
        checks++;
        if (dout_valid !== 1'b0 || dout !== 8'h00 || busy !== 1'b0 || gnt !== 4'b0000) begin
            fails++;
            $display("FAIL midrst_outputs: got v=%b d=%h b=%b g=%b expected all 0", dout_valid, dout, busy, gnt);
        end
        step();
        reset_n = 1'b1;
        dv_bad = 0;
        n = 0;
        do begin
            step();
            n++;
            if (dout_valid === 1'b1) dv_bad = 1;
        end while (gnt === 4'b0000 && n < 5);
        checks++;
        if (gnt !== 4'b1000 || n != 1) begin fails++; $display("FAIL midrst_gnt: got %b after %0d expected 1000 after 1", gnt, n); end
        checks++;
        if (dv_bad) begin fails++; $display("FAIL midrst_aborted_valid: got dout_valid expected none"); end
        req = '0;
        wait_valid(n, 12);
        checks++;
        if (dout_valid !== 1'b1 || n != MAX || dout !== reverse(y) || dout_id !== 2'd3) begin
            fails++;
            $display("FAIL midrst_result: got %h/%0d after %0d expected %h/3 after %0d", dout, dout_id, n, reverse(y), MAX);
        end
        step();
    endtask

    task automatic test_random;
        logic [3:0] mask;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            mask = 4'($urandom_range(1, 15));
            run_batch("random", mask, 4'b0000, 32'($urandom), $countones(mask));
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_late_request();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_bitrev_sched

// File: doc/bitrev_sched.md
# bitrev_sched

Round-robin scheduler that shares one iterative bit-reversal engine between `NREQ` requesters. The engine computes the same result as the team's `reverse` function, `out[MAX-1-k] = Din[k]`, one bit per clock, so the datapath stays a single shift register instead of a wide mux per requester. It sits between the requesting datapath blocks and any consumer of reversed words. It owns arbitration, the operand capture handshake, sequencing of the shift, and result delivery.

## Interface
- `MAX`, default 8: data width in bits; legal range is 2 or more.
- `NREQ`, default 4: number of requesters; legal range is 2 or more.
- `IDW` (localparam): `$clog2(NREQ)`.
- `clk`, input, 1: single clock, rising-edge.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, `NREQ`: per-requester request level.
- `din`, input, `NREQ*MAX`: flattened operands; requester i occupies `din[i*MAX +: MAX]`.
- `gnt`, output, `NREQ`: one-hot grant pulse, one cycle.
- `busy`, output, 1: engine occupied (state ≠ IDLE).
- `dout`, output, `MAX`: reversed result, held until the next completion.
- `dout_id`, output, `IDW`: index of the requester that owns `dout`.
- `dout_valid`, output, 1: one-cycle pulse marking a new `dout`.

## Operation
- FSM states:
  - **IDLE**: arbitrate on each edge.
  - **SHIFT**: reverse the captured operand.
- **IDLE → SHIFT**, on an edge with `|req`:
  - Winner = first set `req` bit, searching upward from `(last_id+1) mod NREQ`.
  - Capture `src ← din[winner]`, `acc ← 0`, `cnt ← 0`, `last_id ← winner`.
  - Register `gnt ← onehot(winner)` and `cur_id ← winner`.
- **SHIFT**, each edge:
  - `acc ← {acc[MAX-2:0], src[0]}`, `src ← src >> 1`, `cnt ← cnt + 1`.
- **SHIFT → IDLE**, on the edge where `cnt == MAX-1`:
  - `dout ← {acc[MAX-2:0], src[0]}`, `dout_id ← cur_id`, `dout_valid ← 1`.
- `gnt` and `dout_valid` are registered pulses, cleared on the following edge.
- Requesters hold `req` and `din` stable until they see their `gnt` bit, then drop `req`.
  - `din` is sampled only at the capture edge.
- `req` changes while in SHIFT are ignored. There is no preemption.
- `req == 0` in IDLE: stay in IDLE, `last_id` unchanged.
- `cnt` width is `$clog2(MAX)`; it never wraps past `MAX-1`.

## Timing
- Reset values, while `reset_n` is low: `gnt = 0`, `busy = 0`, `dout = 0`, `dout_id = 0`, `dout_valid = 0`, state = IDLE, `last_id = NREQ-1`.
  - Because `last_id` resets to `NREQ-1`, requester 0 has top priority on the first arbitration.
- Let capture edge = E0.
  - `gnt` is high for the cycle after E0.
  - Shift edges are E1..E_MAX.
  - `dout` and `dout_valid` appear in the cycle after E_MAX.
- Latency from capture edge to valid result: `MAX` cycles.
- Throughput: a new capture can occur at E_MAX+1, so one operation per `MAX+1` cycles.
  - In that cycle `dout_valid` of the previous operation and the next `gnt` are adjacent, never overlapping.
- `busy` is high from the cycle after E0 through the cycle after E_MAX-1. It is low in the `dout_valid` cycle.
- Reset asserted mid-SHIFT: the operation is aborted and no `dout_valid` is produced. Arbitration restarts from requester 0.

## Structure
- Package `bitrev_pkg` contains:
  - the state enum `{IDLE, SHIFT}`;
  - default `MAX`/`NREQ` constants;
  - the `reverse` function, used only by the bench as the reference model.
- Sub-module `bitrev_rr_arbiter` contains:
  - a combinational winner search from `last_id+1`;
  - an `any` output.
  - `last_id` itself stays in the top level, which updates it only on capture.
- The top level holds the FSM, `src`, `acc`, `cnt`, and the output registers.

## Test plan
All scenarios use `MAX=8`, `NREQ=4`.
- Reset: drive `reset_n = 0` with `req = 4'hF` → all outputs 0 and `busy = 0`; after release, the first `gnt` is `4'b0001`.
- Single request: `req = 0001`, `din0 = 8'h01` → `gnt = 0001` for one cycle; then `dout = 8'h80`, `dout_id = 0`, and `dout_valid` 8 cycles after the capture edge.
- All four requesting, each dropping `req` on its `gnt`; `din` = `8'hA0`, `8'h0F`, `8'h3C`, `8'h01` → grants arrive in order 0, 1, 2, 3, 9 cycles apart; `dout` = `8'h05`, `8'hF0`, `8'h3C`, `8'h80`.
- Fairness: `req[1]` and `req[3]` held high permanently → grants alternate 1, 3, 1, 3.
- Late request: `req[2]` rises at shift count 3 → no `gnt` until the edge after `dout_valid`, then `gnt = 0100`.
- Mid-operation reset: pull `reset_n` low at count 4 → no `dout_valid` occurs, `dout = 0`; a pending `req = 1000` after release → `gnt = 1000`, and the result is correct.
